// File: rtl/lcd_shadow.sv
// lcd_shadow: passive listener on an HD44780-style 8-bit LCD bus.
// Decodes the controller's instruction/data stream the same way the panel
// would and keeps a shadow of the 2x16 DDRAM plus the display mode bits.
// Shadow contents are read back through a registered read port.
// Optional feature macro: LCD_SHADOW_BUSY_EN enables the emulated busy flag
// and the overrun pulse; without it both outputs are tied low.
module lcd_shadow #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E,
  input  logic       RS,
  input  logic       RW,
  input  logic [7:0] DB,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       bus_8bit,
  output logic       wr_pulse,
  output logic       unsup,
  output logic       busy,
  output logic       overrun
);

  logic       e_d;
  logic       rs_d;
  logic       rw_d;
  logic [7:0] db_d;
  logic       xfer;
  logic       entry_id;
  logic       cgram_mode;
  logic [7:0] shadow [32];

  // Address counter step; the two DDRAM lines are 0x00-0x27 and 0x40-0x67,
  // so stepping off the end of one line lands on the start of the other.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    nxt = ac;
    if (inc) begin
      if (ac == 7'h27)      nxt = 7'h40;
      else if (ac == 7'h67) nxt = 7'h00;
      else                  nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h40)      nxt = 7'h27;
      else if (ac == 7'h00) nxt = 7'h67;
      else                  nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  // The bus is registered once so a transfer uses the values held while E was high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_d  <= 1'b0;
      rs_d <= 1'b0;
      rw_d <= 1'b0;
      db_d <= 8'h00;
    end else begin
      e_d  <= E;
      rs_d <= RS;
      rw_d <= RW;
      db_d <= DB;
    end
  end

  // A transfer happens in the first cycle E is seen low after being high.
  assign xfer = e_d & ~E;

  // Instruction/data execution, shadow update and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      cursor_addr <= 7'h00;
      entry_id    <= 1'b1;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      bus_8bit    <= 1'b1;
      two_line    <= 1'b0;
      cgram_mode  <= 1'b0;
      wr_pulse    <= 1'b0;
      unsup       <= 1'b0;
      rd_char     <= 8'h20;
    end else begin
      wr_pulse <= 1'b0;
      unsup    <= 1'b0;
      // Reading before any write this cycle gives old-value semantics on a collision.
      rd_char  <= shadow[rd_idx];
      if (xfer) begin
        if (rw_d) begin
          unsup <= 1'b1;
        end else if (!rs_d) begin
          casez (db_d)
            8'b1???????: begin
              cursor_addr <= db_d[6:0];
              cgram_mode  <= 1'b0;
            end
            8'b01??????: begin
              cgram_mode <= 1'b1;
              unsup      <= 1'b1;
            end
            8'b001?????: begin
              bus_8bit <= db_d[4];
              two_line <= db_d[3];
            end
            8'b0001????: begin
              if (db_d[3]) unsup <= 1'b1;
              else         cursor_addr <= ac_step(cursor_addr, db_d[2]);
            end
            8'b00001???: begin
              disp_on   <= db_d[2];
              cursor_on <= db_d[1];
              blink_on  <= db_d[0];
            end
            8'b000001??: begin
              entry_id <= db_d[1];
              if (db_d[0]) unsup <= 1'b1;
            end
            8'b0000001?: begin
              cursor_addr <= 7'h00;
              cgram_mode  <= 1'b0;
            end
            8'b00000001: begin
              for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
              cursor_addr <= 7'h00;
              entry_id    <= 1'b1;
              cgram_mode  <= 1'b0;
            end
            default: ;
          endcase
        end else begin
          if (cgram_mode) begin
            unsup <= 1'b1;
          end else if (cursor_addr[5:4] == 2'b00) begin
            shadow[{cursor_addr[6], cursor_addr[3:0]}] <= db_d;
            wr_pulse <= 1'b1;
          end
          cursor_addr <= ac_step(cursor_addr, entry_id);
        end
      end
    end
  end

`ifdef LCD_SHADOW_BUSY_EN
  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             long_op;

  // Clear and Return Home take the long execution time; everything else the short one.
  assign long_op = ~rw_d & ~rs_d & (db_d[7:2] == 6'd0) & (db_d[1:0] != 2'd0);

  // Busy countdown; a transfer arriving while busy only flags overrun, it never restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (xfer && (busy_cnt != '0)) overrun <= 1'b1;
      if (xfer && (busy_cnt == '0))
        busy_cnt <= long_op ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - 1'b1;
    end
  end

  assign busy = (busy_cnt != '0);
`else
  logic unused_cfg;
  assign unused_cfg = ^{BUSY_CYCLES[0], CLEAR_CYCLES[0]};
  assign busy       = 1'b0;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_shadow.sv
// Testbench for lcd_shadow: table of bus transfers with expected AC/mode/pulses,
// scoreboard queue of per-transfer expectations, and hand sequences for
// readback, read/write collision, Clear, reset and (with LCD_SHADOW_BUSY_EN) busy timing.
module tb_lcd_shadow;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       E = 1'b0;
  logic       RS = 1'b0;
  logic       RW = 1'b0;
  logic [7:0] DB = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       disp_on, cursor_on, blink_on, two_line, bus_8bit;
  logic       wr_pulse, unsup, busy, overrun;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] db;
    logic [6:0] ac;
    logic       wr;
    logic       uns;
    logic [4:0] mode;
  } vec_t;

  typedef struct {
    string      name;
    logic       wr;
    logic       uns;
    logic       ovr;
    logic       ovr_chk;
    logic [6:0] ac;
    logic [4:0] mode;
  } exp_t;

  exp_t       sb[$];
  vec_t       tbl[$];
  logic [7:0] exp_buf [32];
  int         tests = 0;
  int         fails = 0;
  int         k;
`ifdef LCD_SHADOW_BUSY_EN
  logic       tbl_ovr_chk = 1'b0;
`else
  logic       tbl_ovr_chk = 1'b1;
`endif

  lcd_shadow dut (
    .clk(clk), .reset(reset), .E(E), .RS(RS), .RW(RW), .DB(DB),
    .rd_idx(rd_idx), .rd_char(rd_char), .cursor_addr(cursor_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .bus_8bit(bus_8bit), .wr_pulse(wr_pulse),
    .unsup(unsup), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.name, ".wr_pulse"}, 32'(wr_pulse), 32'(e.wr));
      check({e.name, ".unsup"}, 32'(unsup), 32'(e.uns));
      check({e.name, ".ac"}, 32'(cursor_addr), 32'(e.ac));
      check({e.name, ".mode"}, 32'({disp_on, cursor_on, blink_on, two_line, bus_8bit}), 32'(e.mode));
      if (e.ovr_chk) check({e.name, ".overrun"}, 32'(overrun), 32'(e.ovr));
    end
  endtask

  // Called at a falling clock edge: E high for one cycle, low for one, then sample at F+1.
  task automatic applyStimulus(input vec_t v, input string name, input logic ovr, input logic ovr_chk);
    exp_t e;
    e.name = name; e.wr = v.wr; e.uns = v.uns; e.ovr = ovr; e.ovr_chk = ovr_chk;
    e.ac = v.ac; e.mode = v.mode;
    sb.push_back(e);
    E = 1'b1; RS = v.rs; RW = v.rw; DB = v.db;
    @(negedge clk);
    E = 1'b0;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic readBack(input string name);
    for (int i = 0; i < 32; i++) begin
      rd_idx = 5'(i);
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), 32'(rd_char), 32'(exp_buf[i]));
    end
  endtask

  initial begin
    // Mode field is {disp_on, cursor_on, blink_on, two_line, bus_8bit}.
    tbl.push_back('{0, 0, 8'h38, 7'h00, 0, 0, 5'b00011});
    tbl.push_back('{0, 0, 8'h0F, 7'h00, 0, 0, 5'b11111});
    tbl.push_back('{0, 0, 8'h0E, 7'h00, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h06, 7'h00, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h80, 7'h00, 0, 0, 5'b11011});
    tbl.push_back('{1, 0, 8'h48, 7'h01, 1, 0, 5'b11011});
    tbl.push_back('{1, 0, 8'h69, 7'h02, 1, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'hC0, 7'h40, 0, 0, 5'b11011});
    tbl.push_back('{1, 0, 8'h41, 7'h41, 1, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'hA7, 7'h27, 0, 0, 5'b11011});
    tbl.push_back('{1, 0, 8'h5A, 7'h40, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h04, 7'h40, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h80, 7'h00, 0, 0, 5'b11011});
    tbl.push_back('{1, 0, 8'h20, 7'h67, 1, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h1C, 7'h67, 0, 1, 5'b11011});
    tbl.push_back('{0, 0, 8'h10, 7'h66, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h14, 7'h67, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h14, 7'h00, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h06, 7'h00, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h10, 7'h67, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h07, 7'h67, 0, 1, 5'b11011});
    tbl.push_back('{0, 0, 8'h06, 7'h67, 0, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'hCF, 7'h4F, 0, 0, 5'b11011});
    tbl.push_back('{1, 0, 8'h7A, 7'h50, 1, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h40, 7'h50, 0, 1, 5'b11011});
    tbl.push_back('{1, 0, 8'h55, 7'h51, 0, 1, 5'b11011});
    tbl.push_back('{0, 1, 8'h01, 7'h51, 0, 1, 5'b11011});
    tbl.push_back('{1, 1, 8'h33, 7'h51, 0, 1, 5'b11011});
    tbl.push_back('{0, 0, 8'h02, 7'h00, 0, 0, 5'b11011});
    tbl.push_back('{1, 0, 8'h42, 7'h01, 1, 0, 5'b11011});
    tbl.push_back('{0, 0, 8'h20, 7'h01, 0, 0, 5'b11000});
    tbl.push_back('{0, 0, 8'h08, 7'h01, 0, 0, 5'b00000});

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.ac", 32'(cursor_addr), 32'h00);
    check("rst.mode", 32'({disp_on, cursor_on, blink_on, two_line, bus_8bit}), 32'b00001);
    check("rst.rd_char", 32'(rd_char), 32'h20);
    check("rst.pulses", 32'({wr_pulse, unsup, overrun, busy}), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Table of back-to-back transfers at the minimum 2-cycle spacing.
    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i], $sformatf("vec%0d", i), 1'b0, tbl_ovr_chk);

    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    exp_buf[0] = 8'h42; exp_buf[1] = 8'h69; exp_buf[16] = 8'h41; exp_buf[31] = 8'h7A;
    readBack("buf");

    // Write and read of the same entry in one cycle returns the old value first.
    rd_idx = 5'd2;
    applyStimulus('{0, 0, 8'h82, 7'h02, 0, 0, 5'b00000}, "coll.addr", 1'b0, 1'b0);
    applyStimulus('{1, 0, 8'h77, 7'h03, 1, 0, 5'b00000}, "coll.wr", 1'b0, 1'b0);
    check("coll.old", 32'(rd_char), 32'h20);
    @(negedge clk);
    check("coll.new", 32'(rd_char), 32'h77);
    check("coll.wr_once", 32'(wr_pulse), 32'h0);

    // Clear also restores ID=1 so the following write increments.
    applyStimulus('{0, 0, 8'h04, 7'h03, 0, 0, 5'b00000}, "clr.id0", 1'b0, 1'b0);
    applyStimulus('{0, 0, 8'h01, 7'h00, 0, 0, 5'b00000}, "clr", 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    readBack("clr");
    applyStimulus('{1, 0, 8'h35, 7'h01, 1, 0, 5'b00000}, "clr.wr", 1'b0, 1'b0);

    // Reset mid-transfer takes effect immediately.
    E = 1'b1; RS = 1'b1; DB = 8'h99;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid.ac", 32'(cursor_addr), 32'h00);
    check("mid.mode", 32'({disp_on, cursor_on, blink_on, two_line, bus_8bit}), 32'b00001);
    check("mid.rd_char", 32'(rd_char), 32'h20);
    check("mid.pulses", 32'({wr_pulse, unsup, overrun, busy}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    E = 1'b0;
    rd_idx = 5'd0;
    @(negedge clk);
    check("rel.wr_pulse", 32'(wr_pulse), 32'h0);
    check("rel.ac", 32'(cursor_addr), 32'h00);
    @(negedge clk);
    check("rel.buf0", 32'(rd_char), 32'h20);

`ifdef LCD_SHADOW_BUSY_EN
    // Overrun: data arrives 10 cycles after an instruction; busy timing follows the first edge.
    applyStimulus('{0, 0, 8'h0C, 7'h00, 0, 0, 5'b10001}, "ovr.cmd", 1'b0, 1'b1);
    k = 1;
    check("ovr.busy_start", 32'(busy), 32'h1);
    repeat (8) begin @(negedge clk); k++; end
    applyStimulus('{1, 0, 8'h31, 7'h01, 1, 0, 5'b10001}, "ovr.data", 1'b1, 1'b1);
    k += 2;
    while (k < 2000) begin @(negedge clk); k++; end
    check("ovr.busy_last", 32'(busy), 32'h1);
    @(negedge clk);
    check("ovr.busy_end", 32'(busy), 32'h0);
    rd_idx = 5'd0;
    @(negedge clk);
    check("ovr.buf0", 32'(rd_char), 32'h31);

    // Clear holds busy for the long execution time.
    applyStimulus('{0, 0, 8'h01, 7'h00, 0, 0, 5'b10001}, "busy.clr", 1'b0, 1'b1);
    repeat (76499) @(negedge clk);
    check("clr.busy_last", 32'(busy), 32'h1);
    @(negedge clk);
    check("clr.busy_end", 32'(busy), 32'h0);
`else
    check("nobusy.busy", 32'(busy), 32'h0);
    check("nobusy.overrun", 32'(overrun), 32'h0);
`endif

    check("sb.empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_shadow.md
# lcd_shadow

Passive responder for the HD44780-style 8-bit LCD bus (E/RS/RW/DB) driven by the display controller. It decodes the instruction and data stream exactly as the panel would and keeps a shadow copy of the 2×16 DDRAM contents and the display mode. The shadow feeds on-chip consumers such as the VGA mirror, 7-segment debug, and bench scoreboards through a registered read port, and flags protocol violations.

## Interface
- `BUSY_CYCLES`, default 2000, emulated execution time of a normal instruction or data write (40 µs at 50 MHz).
- `CLEAR_CYCLES`, default 76500, emulated execution time of Clear and Return Home (1.53 ms at 50 MHz).
- `clk`, input, 1, master 50 MHz clock.
- `reset`, input, 1, asynchronous active-low reset.
- `E`, input, 1, LCD enable; a transfer is latched on its falling edge.
- `RS`, input, 1, 0 = instruction, 1 = data.
- `RW`, input, 1, 1 = read (unsupported).
- `DB`, input, 8, bus data.
- `rd_idx`, input, 5, shadow index: 0–15 is line 1, 16–31 is line 2.
- `rd_char`, output, 8, ASCII at `rd_idx`, registered.
- `cursor_addr`, output, 7, address counter (AC).
- `disp_on`, `cursor_on`, `blink_on`, output, 1 each, Display Control D/C/B bits.
- `two_line`, `bus_8bit`, output, 1 each, Function Set N and DL bits.
- `wr_pulse`, output, 1, one-cycle pulse per accepted DDRAM character write.
- `unsup`, output, 1, one-cycle pulse on an unsupported transfer.
- `busy`, output, 1, emulated busy flag.
- `overrun`, output, 1, one-cycle pulse when a transfer arrives while `busy` is high.

## Operation
- **Input stage.** E, RS, RW and DB are registered once each cycle (E_d, RS_d, RW_d, DB_d). A transfer occurs when E_d=1 and E=0. The transfer uses RS_d, RW_d and DB_d, i.e. the values held while E was high.
- **Reset values.**
  - Shadow buffer: all 32 entries 0x20.
  - AC=0x00, ID=1, S=0, D=C=B=0, DL=1, N=0.
  - cgram_mode=0, busy=0, all pulses 0, rd_char=0x20.
- **RW=1 transfer:** `unsup` pulses; no state change.
- **Instruction decode (RS=0)** uses the highest set bit of DB:
  - 0x01 Clear: all entries set to 0x20, AC=0, ID=1, cgram_mode=0.
  - 0x02–0x03 Return Home: AC=0, cgram_mode=0.
  - 0x04–0x07 Entry Mode: ID=DB[1], S=DB[0]. S=1 also pulses `unsup` (display shift not modelled).
  - 0x08–0x0F Display Control: D=DB[2], C=DB[1], B=DB[0].
  - 0x10–0x1F Shift: if DB[3]=0, AC is stepped by DB[2] (1 = increment). If DB[3]=1, `unsup` pulses.
  - 0x20–0x3F Function Set: DL=DB[4], N=DB[3].
  - 0x40–0x7F Set CGRAM address: cgram_mode=1 and `unsup` pulses.
  - 0x80–0xFF Set DDRAM address: AC=DB[6:0], cgram_mode=0.
- **Data write (RS=1).**
  - If cgram_mode=1: the data is dropped and `unsup` pulses.
  - Otherwise, if AC is in 0x00–0x0F, entry AC is written. If AC is in 0x40–0x4F, entry AC−0x30 is written. In either case `wr_pulse` fires.
  - Any other AC value: the write is silently dropped.
  - AC then steps by ID in all cases.
- **AC step rules.**
  - Increment: 0x27→0x40 and 0x67→0x00. Every other value is +1 modulo 128.
  - Decrement: 0x40→0x27 and 0x00→0x67. Every other value is −1 modulo 128.
- **Read port.** `rd_char` ← buffer[`rd_idx`] every cycle.
- **Simultaneous write and read.** When a write and a read of the same index occur in the same cycle, `rd_char` returns the old value.

## Timing
- **Latency from the E falling edge (cycle F, first cycle E is sampled low):**
  - Shadow, mode and AC updates are visible at F+1.
  - `wr_pulse` and `unsup` are high during F+1 only.
- **Read latency:** `rd_char` is valid 1 cycle after `rd_idx`.
- **busy:**
  - Asserted at F+1 for CLEAR_CYCLES (Clear, Return Home) or BUSY_CYCLES (all other transfers, including dropped ones).
  - Deasserts exactly that many cycles later.
  - The counter does not restart on an overrun.
- **Overrun:** a transfer whose F falls while `busy`=1 is still fully executed, and `overrun` pulses at F+1.
- **Back-to-back transfers:** the minimum legal spacing is one falling edge per 2 cycles (E high for 1 cycle). No transfer may be lost at that spacing.
- **Reset mid-transfer:** all state returns to reset values immediately. A falling E seen in the first cycle after reset release is ignored because E_d resets to 0.

## Configuration
- `LCD_SHADOW_BUSY_EN` defined: busy counter, `busy` and `overrun` are implemented as described above.
- `LCD_SHADOW_BUSY_EN` undefined: the counter is removed, and `busy` and `overrun` are tied to 0. All other behaviour is identical.

## Test plan
- After reset, send 0x38, 0x0F, 0x0E, 0x06 as instructions with 1-cycle E pulses → two_line=1, bus_8bit=1, disp_on=1, cursor_on=1, blink_on=0, AC=0, no `unsup`.
- Send 0x80, then data 0x48, 0x69 → entries 0 and 1 are 0x48 and 0x69, AC=0x02, two `wr_pulse`s. Then send 0xC0 and data 0x41 → entry 16 = 0x41, AC=0x41.
- Wrap and drop:
  - Send 0xA7 (AC=0x27) and data 0x5A → no buffer change, no `wr_pulse`, AC=0x40.
  - Send 0x04 (ID=0), then 0x80 and data 0x20 → AC=0x67.
- Send Clear (0x01) after filling entries → all 32 reads return 0x20, AC=0. With `LCD_SHADOW_BUSY_EN`, `busy` stays high for 76500 cycles.
- With `LCD_SHADOW_BUSY_EN` on, send 0x0C and then data 0x31 after 10 cycles → `overrun` pulses, the data is still written, and `busy` drops 2000 cycles after the first edge.
- Unsupported transfers each pulse `unsup` once with no buffer change:
  - RW=1 transfer.
  - 0x1C.
  - 0x40 followed by data 0x55.
- Assert reset mid-sequence → all outputs at reset values in the same cycle.
